// File: rtl/key_judge.sv
// key_judge: beat generator and key judge for a one-lane-per-key rhythm game.
// One beat lasts BEAT_DIV cycles of CLOCK_50. game_clock is high for the first
// half of the beat, and the scorer samples on its falling edge. Only the first
// key press in the early part of the beat is judged. A beat that carries a tile
// and has no correct press counts as a miss. After MISS_LIMIT misses the game
// ends.
// Optional macro: KEY_JUDGE_STRICT_WRONG_EN. When it is defined, a wrong press
// on a tile beat counts as a miss straight away, and the end-of-window miss for
// that beat is suppressed.
// o_dbg_state exposes the game FSM (0 idle, 1 run, 2 over) for checkers.
module key_judge #(
  parameter int BEAT_DIV   = 25000000,
  parameter int MISS_LIMIT = 3
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] KEY,
  input  logic [1:0] tile_lane,
  input  logic       tile_valid,
  output logic       game_clock,
  output logic       correct_key_pressed,
  output logic       miss_pulse,
  output logic [3:0] misses,
  output logic       game_over,
  output logic [1:0] o_dbg_state
);

`ifdef KEY_JUDGE_STRICT_WRONG_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  localparam int CW = $clog2(BEAT_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BEAT_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BEAT_DIV / 2);
  localparam logic [CW-1:0] CNT_HM1  = CW'(BEAT_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_HM2  = CW'(BEAT_DIV / 2 - 2);
  localparam logic [CW-1:0] CNT_HP1  = CW'(BEAT_DIV / 2 + 1);
  localparam logic [3:0]    MISS_LIM = 4'(MISS_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [3:0]      r_key_prev;
  logic            r_tile_valid;
  logic [1:0]      r_tile_lane;
  logic            r_judged;
  logic            r_blocked;
  logic            r_correct;
  logic            r_miss_pulse;
  logic [3:0]      r_misses;
  logic            r_game_over;
  logic            r_game_clock;

  logic [3:0]      w_fall;
  logic            w_one_edge;
  logic [1:0]      w_edge_idx;
  logic            w_beat_tv;
  logic [1:0]      w_beat_tl;
  logic            w_judge;
  logic            w_correct;
  logic            w_strict_miss;
  logic            w_beat_miss;
  logic [CW-1:0]   w_cnt_next;
  logic [3:0]      w_misses_inc;

  // Two-flop synchronizer per key plus one delay stage for falling-edge detection.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_sync1    <= 4'hF;
      r_sync2    <= 4'hF;
      r_key_prev <= 4'hF;
    end else begin
      r_sync1    <= KEY;
      r_sync2    <= r_sync1;
      r_key_prev <= r_sync2;
    end
  end

  assign w_fall     = r_key_prev & ~r_sync2;
  assign w_one_edge = ($countones(w_fall) == 1);

  // Lane index of the detected edge (meaningful only when exactly one edge).
  always_comb begin
    w_edge_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_fall[i]) w_edge_idx = 2'(i);
    end
  end

  // At cnt==0 the tile inputs are being latched this very cycle, so use them
  // directly; later in the beat use the latched copy.
  assign w_beat_tv     = (r_cnt == '0) ? tile_valid : r_tile_valid;
  assign w_beat_tl     = (r_cnt == '0) ? tile_lane  : r_tile_lane;
  assign w_judge       = (r_state == ST_RUN) && (w_fall != 4'd0) && !r_judged &&
                         (r_cnt <= CNT_HM2);
  assign w_correct     = w_judge && w_beat_tv && w_one_edge && (w_edge_idx == w_beat_tl);
  assign w_strict_miss = STRICT && w_judge && !w_correct && w_beat_tv;
  // Decided one cycle early so the registered strobe lands on cnt==BEAT_DIV/2.
  assign w_beat_miss   = (r_cnt == CNT_HM1) && r_tile_valid && !r_correct && !r_blocked;
  assign w_cnt_next    = (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
  assign w_misses_inc  = (r_misses == 4'd15) ? r_misses : r_misses + 4'd1;

  // Game FSM with beat counter, judgment flags and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_tile_valid <= 1'b0;
      r_tile_lane  <= 2'd0;
      r_judged     <= 1'b0;
      r_blocked    <= 1'b0;
      r_correct    <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_misses     <= 4'd0;
      r_game_over  <= 1'b0;
      r_game_clock <= 1'b0;
    end else begin
      r_miss_pulse <= 1'b0;
      if (r_cnt == '0) begin
        r_tile_valid <= tile_valid;
        r_tile_lane  <= tile_lane;
      end
      if (start) begin
        // Start wins over everything, including a miss decided this cycle.
        r_state      <= ST_RUN;
        r_cnt        <= '0;
        r_misses     <= 4'd0;
        r_judged     <= 1'b0;
        r_blocked    <= 1'b0;
        r_correct    <= 1'b0;
        r_game_over  <= 1'b0;
        r_game_clock <= 1'b1;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (r_misses >= MISS_LIM) begin
              r_state      <= ST_OVER;
              r_game_over  <= 1'b1;
              r_correct    <= 1'b0;
              r_game_clock <= 1'b0;
              r_cnt        <= '0;
            end else begin
              r_cnt        <= w_cnt_next;
              r_game_clock <= (w_cnt_next < CNT_HALF);
              if (w_judge) r_judged <= 1'b1;
              if (w_correct) r_correct <= 1'b1;
              else if (r_cnt == CNT_HP1) r_correct <= 1'b0;
              if (w_strict_miss) begin
                r_blocked    <= 1'b1;
                r_misses     <= w_misses_inc;
                r_miss_pulse <= 1'b1;
              end else if (w_beat_miss) begin
                r_misses     <= w_misses_inc;
                r_miss_pulse <= 1'b1;
              end
              if (r_cnt == CNT_LAST) begin
                r_judged  <= 1'b0;
                r_blocked <= 1'b0;
              end
            end
          end
          default: begin
            // IDLE and OVER hold everything until start.
          end
        endcase
      end
    end
  end

  assign game_clock          = r_game_clock;
  assign correct_key_pressed = r_correct;
  assign miss_pulse          = r_miss_pulse;
  assign misses              = r_misses;
  assign game_over           = r_game_over;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_key_judge.sv
// tb_key_judge: directed and random stimulus for key_judge (BEAT_DIV=8,
// MISS_LIMIT=2). Expected outputs come from a beat/verdict model: each beat has
// a latched tile and at most one verdict (hit or wrong) recorded with the count
// at which the press was seen.
module tb_key_judge;
  localparam int BD   = 8;
  localparam int ML   = 2;
  localparam int HALF = BD / 2;

`ifdef KEY_JUDGE_STRICT_WRONG_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;
  localparam int V_NONE = 0, V_HIT = 1, V_WRONG = 2;

  // ---------------- clock / reset ----------------
  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       start;
  logic [3:0] KEY;
  logic [1:0] tile_lane;
  logic       tile_valid;
  logic       game_clock;
  logic       correct_key_pressed;
  logic       miss_pulse;
  logic [3:0] misses;
  logic       game_over;
  logic [1:0] o_dbg_state;

  always #5 CLOCK_50 = ~CLOCK_50;

  key_judge #(.BEAT_DIV(BD), .MISS_LIMIT(ML)) dut (
    .CLOCK_50            (CLOCK_50),
    .resetn              (resetn),
    .start               (start),
    .KEY                 (KEY),
    .tile_lane           (tile_lane),
    .tile_valid          (tile_valid),
    .game_clock          (game_clock),
    .correct_key_pressed (correct_key_pressed),
    .miss_pulse          (miss_pulse),
    .misses              (misses),
    .game_over           (game_over),
    .o_dbg_state         (o_dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int         m_mode;
  int         m_cnt;
  int         m_misses;
  int         m_verdict;
  int         m_vcnt;
  bit         m_tv;
  int         m_tl;
  logic [3:0] key_q[$];   // raw KEY of the last three cycles, oldest first

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_cnt     = 0;
    m_misses  = 0;
    m_verdict = V_NONE;
    m_vcnt    = 0;
    m_tv      = 1'b0;
    m_tl      = 0;
    key_q.delete();
    repeat (3) key_q.push_back(4'hF);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check1(input string tag, input logic obs, input logic e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  // ---------------- driver ----------------
  // One clock period: compare outputs with the model, drive this period's
  // inputs, then advance the model across the following rising edge.
  task automatic cycle(input bit st, input bit tv, input int tl, input logic [3:0] key);
    logic [3:0] fall;
    bit         e_pulse;
    @(negedge CLOCK_50);
    e_pulse = 1'b0;
    if (m_mode == M_RUN) begin
      if (m_cnt == HALF && m_tv && m_verdict != V_HIT && !(STRICT && m_verdict == V_WRONG))
        e_pulse = 1'b1;
      if (STRICT && m_verdict == V_WRONG && m_tv && m_cnt == m_vcnt + 1)
        e_pulse = 1'b1;
    end
    if (e_pulse && m_misses < 15) m_misses++;
    check1("game_clock", game_clock, (m_mode == M_RUN) && (m_cnt < HALF));
    check1("correct_key_pressed", correct_key_pressed,
           (m_mode == M_RUN) && (m_verdict == V_HIT) && (m_cnt > m_vcnt) && (m_cnt <= HALF + 1));
    check1("miss_pulse", miss_pulse, e_pulse);
    check4("misses", misses, 4'(m_misses));
    check1("game_over", game_over, m_mode == M_OVER);

    start      = st;
    tile_valid = tv;
    tile_lane  = 2'(tl);
    KEY        = key;

    // A press is seen two cycles after the raw key falls.
    fall = key_q[0] & ~key_q[1];
    if (m_mode == M_RUN && m_cnt == 0) begin
      m_tv = tv;
      m_tl = tl;
    end
    if (m_mode == M_RUN && fall != 4'd0 && m_verdict == V_NONE && m_cnt <= HALF - 2) begin
      m_vcnt    = m_cnt;
      m_verdict = (m_tv && fall == (4'b0001 << m_tl)) ? V_HIT : V_WRONG;
    end
    if (st) begin
      m_mode    = M_RUN;
      m_cnt     = 0;
      m_misses  = 0;
      m_verdict = V_NONE;
    end else if (m_mode == M_RUN) begin
      if (m_misses >= ML) begin
        m_mode = M_OVER;
      end else begin
        m_cnt = (m_cnt + 1) % BD;
        if (m_cnt == 0) m_verdict = V_NONE;
      end
    end
    key_q.push_back(key);
    void'(key_q.pop_front());
  endtask

  task automatic advance_to(input int c, input bit tv, input int tl);
    for (int n = 0; n < 2 * BD && m_cnt != c; n++) cycle(1'b0, tv, tl, 4'hF);
  endtask

  // Asserts reset mid-cycle, checks that outputs clear at once, then releases.
  task automatic do_reset();
    @(negedge CLOCK_50);
    resetn     = 1'b0;
    start      = 1'b0;
    KEY        = 4'hF;
    tile_valid = 1'b0;
    tile_lane  = 2'd0;
    #1;
    check1("rst_game_clock", game_clock, 1'b0);
    check1("rst_correct", correct_key_pressed, 1'b0);
    check1("rst_miss_pulse", miss_pulse, 1'b0);
    check4("rst_misses", misses, 4'd0);
    check1("rst_game_over", game_over, 1'b0);
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] key_r;
    bit         st;
    bit         tv;
    int         tl;

    resetn     = 1'b0;
    start      = 1'b0;
    KEY        = 4'hF;
    tile_valid = 1'b0;
    tile_lane  = 2'd0;
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    check1("init_game_clock", game_clock, 1'b0);
    check1("init_correct", correct_key_pressed, 1'b0);
    check1("init_miss_pulse", miss_pulse, 1'b0);
    check4("init_misses", misses, 4'd0);
    check1("init_game_over", game_over, 1'b0);
    resetn = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 0, 4'hF);

    // Correct press: KEY[2] seen at cnt=0 of the first beat, tile in lane 2.
    cycle(1'b0, 1'b1, 2, 4'b1011);
    cycle(1'b1, 1'b1, 2, 4'b1011);
    repeat (BD) cycle(1'b0, 1'b1, 2, 4'b1011);
    repeat (BD) cycle(1'b0, 1'b0, 0, 4'hF);

    // Two keys falling together on a lane-2 tile: judged wrong.
    repeat (BD) cycle(1'b0, 1'b1, 2, 4'b1010);
    repeat (BD) cycle(1'b0, 1'b0, 0, 4'hF);

    // Start on the cycle that would produce the limit-reaching miss.
    advance_to(HALF - 1, 1'b1, 1);
    cycle(1'b1, 1'b1, 1, 4'hF);
    repeat (3) cycle(1'b0, 1'b0, 0, 4'hF);

    // Late press: KEY[2] seen at cnt=3, outside the judging window.
    advance_to(1, 1'b1, 2);
    repeat (BD - 1) cycle(1'b0, 1'b1, 2, 4'b1011);
    repeat (BD) cycle(1'b0, 1'b0, 0, 4'hF);

    // Two missed beats end the game; game_clock stays low in OVER.
    cycle(1'b1, 1'b1, 3, 4'hF);
    repeat (2 * BD + 4) cycle(1'b0, 1'b1, 3, 4'hF);

    // Restart from OVER, then reset mid-beat with a miss pending.
    cycle(1'b1, 1'b0, 0, 4'hF);
    advance_to(2, 1'b1, 0);
    do_reset();
    repeat (2 * BD) cycle(1'b0, 1'b1, 0, 4'hF);

    // Random play.
    key_r = 4'hF;
    for (int i = 0; i < 2500; i++) begin
      st = ($urandom_range(0, 39) == 0) || (m_mode != M_RUN && $urandom_range(0, 3) == 0);
      tv = ($urandom_range(0, 3) != 0);
      tl = int'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 9) == 0) key_r[b] = ~key_r[b];
      end
      cycle(st, tv, tl, key_r);
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        key_r = 4'hF;
      end
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
